// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch front end. Owns the architectural fetch PC, runs a
// single-outstanding request/response handshake to instruction memory,
// captures the BTB prediction at grant time and presents the fetched
// instruction with its PC, PC+4 and prediction to the decode stage.
//
// Ports
//   i_clk, i_arst           clock, asynchronous active-high reset
//   i_stall_fetch           decode stall; held instruction is not consumed
//   i_redirect/_pc          execute-stage redirect and its target
//   o_btb_pc                PC presented to the BTB (the PC register)
//   i_btb_*                 BTB lookup result for o_btb_pc
//   o_imem_req/_addr        memory request and word-aligned address
//   i_imem_gnt              request accepted this cycle
//   i_imem_rvalid/_rdata    memory response
//   o_valid, o_instr, o_pc, o_pc_plus4,
//   o_branch_pred_taken, o_btb_way, o_pc_target_pred
//                           registered instruction outputs to decode
//
// state | meaning
// INIT  | one idle cycle after reset release
// REQ   | request PC to memory, waiting for grant
// WAIT  | request in flight, waiting for response
// HOLD  | instruction presented to decode, waiting for it to be consumed
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int                    ADDR_WIDTH  = 64,
    parameter int                    INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(64'h0000_0000_8000_0000)
) (
    input  logic                   i_clk,
    input  logic                   i_arst,
    input  logic                   i_stall_fetch,
    input  logic                   i_redirect,
    input  logic [ADDR_WIDTH-1:0]  i_redirect_pc,
    output logic [ADDR_WIDTH-1:0]  o_btb_pc,
    input  logic                   i_btb_hit,
    input  logic                   i_btb_taken,
    input  logic [1:0]             i_btb_way,
    input  logic [ADDR_WIDTH-1:0]  i_btb_target,
    output logic                   o_imem_req,
    output logic [ADDR_WIDTH-1:0]  o_imem_addr,
    input  logic                   i_imem_gnt,
    input  logic                   i_imem_rvalid,
    input  logic [INSTR_WIDTH-1:0] i_imem_rdata,
    output logic                   o_valid,
    output logic [INSTR_WIDTH-1:0] o_instr,
    output logic [ADDR_WIDTH-1:0]  o_pc,
    output logic [ADDR_WIDTH-1:0]  o_pc_plus4,
    output logic                   o_branch_pred_taken,
    output logic [1:0]             o_btb_way,
    output logic [ADDR_WIDTH-1:0]  o_pc_target_pred
);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_pc;
    logic                    r_kill;
    logic                    r_pred_taken;
    logic [1:0]              r_pred_way;
    logic [ADDR_WIDTH-1:0]   r_pred_target;

    logic                    r_valid;
    logic [INSTR_WIDTH-1:0]  r_instr;
    logic [ADDR_WIDTH-1:0]   r_out_pc;
    logic [ADDR_WIDTH-1:0]   r_out_pc_plus4;
    logic                    r_out_pred_taken;
    logic [1:0]              r_out_way;
    logic [ADDR_WIDTH-1:0]   r_out_target;

    logic [ADDR_WIDTH-1:0]   w_redirect_pc;
    logic [ADDR_WIDTH-1:0]   w_pc_plus4;
    logic [ADDR_WIDTH-1:0]   w_seq_next_pc;

    assign w_redirect_pc = i_redirect_pc & ALIGN_MASK;
    assign w_pc_plus4    = r_pc + ADDR_WIDTH'(4);
    // The BTB target is forced to word alignment so the request address
    // never carries low bits.
    assign w_seq_next_pc = r_pred_taken ? (r_pred_target & ALIGN_MASK) : w_pc_plus4;

    assign o_btb_pc            = r_pc;
    assign o_imem_req          = (r_state == ST_REQ);
    assign o_imem_addr         = (r_state == ST_REQ) ? (r_pc & ALIGN_MASK) : '0;
    assign o_valid             = r_valid;
    assign o_instr             = r_instr;
    assign o_pc                = r_out_pc;
    assign o_pc_plus4          = r_out_pc_plus4;
    assign o_branch_pred_taken = r_out_pred_taken;
    assign o_btb_way           = r_out_way;
    assign o_pc_target_pred    = r_out_target;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_state          <= ST_INIT;
            r_pc             <= RESET_PC;
            r_kill           <= 1'b0;
            r_pred_taken     <= 1'b0;
            r_pred_way       <= '0;
            r_pred_target    <= '0;
            r_valid          <= 1'b0;
            r_instr          <= '0;
            r_out_pc         <= '0;
            r_out_pc_plus4   <= '0;
            r_out_pred_taken <= 1'b0;
            r_out_way        <= '0;
            r_out_target     <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_state <= ST_REQ;
                    if (i_redirect) begin
                        r_pc <= w_redirect_pc;
                    end
                end

                ST_REQ: begin
                    if (i_imem_gnt) begin
                        r_pred_taken  <= i_btb_hit & i_btb_taken;
                        r_pred_way    <= i_btb_way;
                        r_pred_target <= i_btb_target;
                        r_state       <= ST_WAIT;
                    end
                    if (i_redirect) begin
                        r_pc <= w_redirect_pc;
                        // Old address already granted: its response must be dropped.
                        if (i_imem_gnt) begin
                            r_kill <= 1'b1;
                        end
                    end
                end

                ST_WAIT: begin
                    if (i_imem_rvalid) begin
                        r_kill <= 1'b0;
                        if (r_kill || i_redirect) begin
                            r_state <= ST_REQ;
                        end else begin
                            r_valid          <= 1'b1;
                            r_instr          <= i_imem_rdata;
                            r_out_pc         <= r_pc;
                            r_out_pc_plus4   <= w_pc_plus4;
                            r_out_pred_taken <= r_pred_taken;
                            r_out_way        <= r_pred_way;
                            r_out_target     <= r_pred_target;
                            r_state          <= ST_HOLD;
                        end
                    end else if (i_redirect) begin
                        r_kill <= 1'b1;
                    end
                    if (i_redirect) begin
                        r_pc <= w_redirect_pc;
                    end
                end

                ST_HOLD: begin
                    if (i_redirect || !i_stall_fetch) begin
                        r_valid          <= 1'b0;
                        r_instr          <= '0;
                        r_out_pc         <= '0;
                        r_out_pc_plus4   <= '0;
                        r_out_pred_taken <= 1'b0;
                        r_out_way        <= '0;
                        r_out_target     <= '0;
                        r_pc             <= i_redirect ? w_redirect_pc : w_seq_next_pc;
                        r_state          <= ST_REQ;
                    end
                end

                default: begin
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

    logic        i_clk = 1'b0;
    logic        i_arst;
    logic        i_stall_fetch;
    logic        i_redirect;
    logic [63:0] i_redirect_pc;
    logic [63:0] o_btb_pc;
    logic        i_btb_hit;
    logic        i_btb_taken;
    logic [1:0]  i_btb_way;
    logic [63:0] i_btb_target;
    logic        o_imem_req;
    logic [63:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        o_valid;
    logic [31:0] o_instr;
    logic [63:0] o_pc;
    logic [63:0] o_pc_plus4;
    logic        o_branch_pred_taken;
    logic [1:0]  o_btb_way;
    logic [63:0] o_pc_target_pred;

    fetch_unit #(.ADDR_WIDTH(64), .INSTR_WIDTH(32), .RESET_PC(RESET_PC)) dut (
        .i_clk(i_clk), .i_arst(i_arst), .i_stall_fetch(i_stall_fetch),
        .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc), .o_btb_pc(o_btb_pc),
        .i_btb_hit(i_btb_hit), .i_btb_taken(i_btb_taken), .i_btb_way(i_btb_way),
        .i_btb_target(i_btb_target), .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
        .i_imem_gnt(i_imem_gnt), .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
        .o_valid(o_valid), .o_instr(o_instr), .o_pc(o_pc), .o_pc_plus4(o_pc_plus4),
        .o_branch_pred_taken(o_branch_pred_taken), .o_btb_way(o_btb_way),
        .o_pc_target_pred(o_pc_target_pred)
    );

    always #5 i_clk = ~i_clk;

    // Reference BTB content and memory image, as pure functions of the PC.
    function automatic logic m_hit(input logic [63:0] pc);
        return pc[4] ^ pc[6];
    endfunction
    function automatic logic m_taken(input logic [63:0] pc);
        return pc[5] | pc[8];
    endfunction
    function automatic logic [1:0] m_way(input logic [63:0] pc);
        return pc[3:2] ^ pc[9:8];
    endfunction
    function automatic logic [63:0] m_tgt(input logic [63:0] pc);
        return (pc ^ 64'h0000_0000_0000_0F30) & ~64'h3;
    endfunction
    function automatic logic [31:0] m_mem(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    logic        btb_force;
    logic        f_hit, f_taken;
    logic [1:0]  f_way;
    logic [63:0] f_tgt;
    assign i_btb_hit    = btb_force ? f_hit   : m_hit(o_btb_pc);
    assign i_btb_taken  = btb_force ? f_taken : m_taken(o_btb_pc);
    assign i_btb_way    = btb_force ? f_way   : m_way(o_btb_pc);
    assign i_btb_target = btb_force ? f_tgt   : m_tgt(o_btb_pc);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        stall, redir;
        logic [63:0] rpc;
        logic        gnt, rvalid;
        logic [31:0] rdata;
        logic        hit, taken;
        logic [1:0]  way;
        logic [63:0] tgt;
        logic        e_req;
        logic [63:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [63:0] e_pc;
        logic        e_pt;
        logic [1:0]  e_way;
        logic [63:0] e_tgt;
    } vec_t;

    function automatic vec_t V(
        input logic stall, input logic redir, input logic [63:0] rpc,
        input logic gnt, input logic rvalid, input logic [31:0] rdata,
        input logic hit, input logic taken, input logic [1:0] way, input logic [63:0] tgt,
        input logic e_req, input logic [63:0] e_addr,
        input logic e_valid, input logic [31:0] e_instr, input logic [63:0] e_pc,
        input logic e_pt, input logic [1:0] e_way, input logic [63:0] e_tgt);
        vec_t v;
        v.stall = stall; v.redir = redir; v.rpc = rpc; v.gnt = gnt; v.rvalid = rvalid;
        v.rdata = rdata; v.hit = hit; v.taken = taken; v.way = way; v.tgt = tgt;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_instr = e_instr;
        v.e_pc = e_pc; v.e_pt = e_pt; v.e_way = e_way; v.e_tgt = e_tgt;
        return v;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive_idle();
        i_stall_fetch = 0; i_redirect = 0; i_redirect_pc = '0;
        i_imem_gnt = 0; i_imem_rvalid = 0; i_imem_rdata = '0;
    endtask

    vec_t        vt[$];
    logic [63:0] model_pc, held_pc, rpc, pend_addr;
    logic        prev_valid, expect_held, expect_clear, gnt, stall, redir;
    int          pend, pend_dly, idle;

    localparam logic [31:0] JUNK = 32'hBAD0_BAD0;
    localparam logic [63:0] A0   = 64'h8000_0000;

    initial begin
        // stall redir rpc | gnt rvalid rdata | hit taken way tgt | req addr | valid instr pc | pt way tgt
        vt.push_back(V(0,0,0,              0,1,JUNK,         0,0,0,0,             0,0,                 0,0,0,0,0,0));
        vt.push_back(V(0,0,0,              1,0,0,            0,0,0,0,             1,A0,                0,0,0,0,0,0));
        vt.push_back(V(0,0,0,              0,1,32'h13,       0,0,0,0,             0,0,                 0,0,0,0,0,0));
        vt.push_back(V(0,0,0,              0,1,JUNK,         0,0,0,0,             0,0,                 1,32'h13,A0,0,0,0));
        vt.push_back(V(0,0,0,              1,0,0,            1,1,2,64'h8000_0100, 1,64'h8000_0004,     0,0,0,0,0,0));
        vt.push_back(V(0,0,0,              0,1,32'hAAAA_0001,0,0,0,0,             0,0,                 0,0,0,0,0,0));
        vt.push_back(V(1,0,0,              0,0,0,            0,0,0,0,             0,0,                 1,32'hAAAA_0001,64'h8000_0004,1,2,64'h8000_0100));
        vt.push_back(V(1,0,0,              0,1,JUNK,         0,0,0,0,             0,0,                 1,32'hAAAA_0001,64'h8000_0004,1,2,64'h8000_0100));
        vt.push_back(V(1,0,0,              0,0,0,            0,0,0,0,             0,0,                 1,32'hAAAA_0001,64'h8000_0004,1,2,64'h8000_0100));
        vt.push_back(V(1,0,0,              0,0,0,            0,0,0,0,             0,0,                 1,32'hAAAA_0001,64'h8000_0004,1,2,64'h8000_0100));
        vt.push_back(V(0,0,0,              0,0,0,            0,0,0,0,             0,0,                 1,32'hAAAA_0001,64'h8000_0004,1,2,64'h8000_0100));
        vt.push_back(V(0,0,0,              0,1,JUNK,         0,0,0,0,             1,64'h8000_0100,     0,0,0,0,0,0));
        vt.push_back(V(0,0,0,              1,0,0,            0,0,0,0,             1,64'h8000_0100,     0,0,0,0,0,0));
        vt.push_back(V(0,1,64'h8000_0503,  0,0,0,            0,0,0,0,             0,0,                 0,0,0,0,0,0));
        vt.push_back(V(0,1,64'h8000_0203,  0,0,0,            0,0,0,0,             0,0,                 0,0,0,0,0,0));
        vt.push_back(V(0,0,0,              0,1,32'hDEAD_BEEF,0,0,0,0,             0,0,                 0,0,0,0,0,0));
        vt.push_back(V(0,0,0,              1,0,0,            1,0,1,64'h8000_0900, 1,64'h8000_0200,     0,0,0,0,0,0));
        vt.push_back(V(0,0,0,              0,1,32'h1111_0000,0,0,0,0,             0,0,                 0,0,0,0,0,0));
        vt.push_back(V(0,0,0,              0,0,0,            0,0,0,0,             0,0,                 1,32'h1111_0000,64'h8000_0200,0,1,64'h8000_0900));
        vt.push_back(V(0,1,64'h8000_0300,  1,0,0,            0,0,0,0,             1,64'h8000_0204,     0,0,0,0,0,0));
        vt.push_back(V(0,0,0,              0,1,32'h2222_0000,0,0,0,0,             0,0,                 0,0,0,0,0,0));
        vt.push_back(V(0,0,0,              1,0,0,            0,0,0,0,             1,64'h8000_0300,     0,0,0,0,0,0));
        vt.push_back(V(0,1,64'h8000_0400,  0,1,32'h3333_0000,0,0,0,0,             0,0,                 0,0,0,0,0,0));
        vt.push_back(V(0,0,0,              1,0,0,            0,1,3,64'h8000_0800, 1,64'h8000_0400,     0,0,0,0,0,0));
        vt.push_back(V(0,0,0,              0,1,32'h4444_0000,0,0,0,0,             0,0,                 0,0,0,0,0,0));
        vt.push_back(V(1,1,64'hFFFF_FFFF_FFFF_FFFC, 0,0,0,   0,0,0,0,             0,0,                 1,32'h4444_0000,64'h8000_0400,0,3,64'h8000_0800));
        vt.push_back(V(0,0,0,              1,0,0,            0,0,0,0,             1,64'hFFFF_FFFF_FFFF_FFFC, 0,0,0,0,0,0));
        vt.push_back(V(0,0,0,              0,1,32'h5555_0000,0,0,0,0,             0,0,                 0,0,0,0,0,0));
        vt.push_back(V(0,0,0,              0,0,0,            0,0,0,0,             0,0,                 1,32'h5555_0000,64'hFFFF_FFFF_FFFF_FFFC,0,0,0));
        vt.push_back(V(0,0,0,              1,0,0,            0,0,0,0,             1,64'h0,             0,0,0,0,0,0));

        btb_force = 1; f_hit = 0; f_taken = 0; f_way = 0; f_tgt = '0;
        drive_idle();
        i_arst = 1;
        repeat (2) @(posedge i_clk);
        #1;
        chk("reset_req", 64'(o_imem_req), 0);
        chk("reset_valid", 64'(o_valid), 0);
        chk("reset_instr", 64'(o_instr), 0);
        chk("reset_pc", o_pc, 0);
        i_arst = 0;

        for (int i = 0; i < vt.size(); i++) begin
            i_stall_fetch = vt[i].stall; i_redirect = vt[i].redir; i_redirect_pc = vt[i].rpc;
            i_imem_gnt = vt[i].gnt; i_imem_rvalid = vt[i].rvalid; i_imem_rdata = vt[i].rdata;
            f_hit = vt[i].hit; f_taken = vt[i].taken; f_way = vt[i].way; f_tgt = vt[i].tgt;
            chk($sformatf("row%0d_req", i), 64'(o_imem_req), 64'(vt[i].e_req));
            if (vt[i].e_req) chk($sformatf("row%0d_addr", i), o_imem_addr, vt[i].e_addr);
            chk($sformatf("row%0d_valid", i), 64'(o_valid), 64'(vt[i].e_valid));
            chk($sformatf("row%0d_instr", i), 64'(o_instr), 64'(vt[i].e_instr));
            chk($sformatf("row%0d_pc", i), o_pc, vt[i].e_pc);
            chk($sformatf("row%0d_pc4", i), o_pc_plus4, vt[i].e_valid ? vt[i].e_pc + 64'd4 : 64'd0);
            chk($sformatf("row%0d_pt", i), 64'(o_branch_pred_taken), 64'(vt[i].e_pt));
            chk($sformatf("row%0d_way", i), 64'(o_btb_way), 64'(vt[i].e_way));
            chk($sformatf("row%0d_tgt", i), o_pc_target_pred, vt[i].e_tgt);
            tick();
        end

        // Asynchronous reset while a request to address 0 is in flight.
        drive_idle();
        i_arst = 1;
        #1;
        chk("arst_req", 64'(o_imem_req), 0);
        chk("arst_addr", o_imem_addr, 0);
        chk("arst_valid", 64'(o_valid), 0);
        chk("arst_instr", 64'(o_instr), 0);
        chk("arst_pc4", o_pc_plus4, 0);
        chk("arst_tgt", o_pc_target_pred, 0);
        chk("arst_btb_pc", o_btb_pc, RESET_PC);
        tick();
        i_arst = 0;
        i_imem_rvalid = 1; i_imem_rdata = JUNK;
        chk("init_req", 64'(o_imem_req), 0);
        tick();
        i_imem_rvalid = 0;
        chk("restart_req", 64'(o_imem_req), 1);
        chk("restart_addr", o_imem_addr, RESET_PC);
        chk("restart_valid", 64'(o_valid), 0);

        // Randomized run against a transaction-level model.
        btb_force = 0;
        drive_idle();
        i_arst = 1;
        tick();
        i_arst = 0;
        model_pc = RESET_PC; pend = 0; pend_dly = 0; pend_addr = '0; idle = 0;
        prev_valid = 0; expect_held = 0; expect_clear = 0; held_pc = '0;
        for (int c = 0; c < 4000; c++) begin
            if (expect_held) begin
                chk("hold_valid", 64'(o_valid), 1);
                chk("hold_pc", o_pc, held_pc);
            end
            if (expect_clear) begin
                chk("clear_valid", 64'(o_valid), 0);
                chk("clear_instr", 64'(o_instr), 0);
            end
            if (o_valid && !prev_valid) begin
                chk("rnd_pc", o_pc, model_pc);
                chk("rnd_pc4", o_pc_plus4, model_pc + 64'd4);
                chk("rnd_instr", 64'(o_instr), 64'(m_mem(model_pc)));
                chk("rnd_pt", 64'(o_branch_pred_taken), 64'(m_hit(model_pc) & m_taken(model_pc)));
                chk("rnd_way", 64'(o_btb_way), 64'(m_way(model_pc)));
                chk("rnd_tgt", o_pc_target_pred, m_tgt(model_pc));
            end
            if (o_valid) idle = 0;
            else idle++;
            if (idle > 100) begin
                chk("rnd_progress_timeout", 64'(idle), 0);
                break;
            end

            gnt   = ($urandom_range(0, 3) != 0);
            stall = ($urandom_range(0, 2) == 0);
            redir = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 9) == 0) rpc = 64'hFFFF_FFFF_FFFF_FF00 | 64'($urandom_range(0, 255));
            else                           rpc = 64'h8000_0000 + 64'($urandom_range(0, 65535));

            if (pend != 0 && pend_dly == 0) begin
                i_imem_rvalid = 1; i_imem_rdata = m_mem(pend_addr); pend = 0;
            end else begin
                if (pend != 0) pend_dly--;
                i_imem_rvalid = (pend == 0) && ($urandom_range(0, 7) == 0);
                i_imem_rdata  = JUNK;
            end

            if (o_imem_req && pend != 0) chk("single_outstanding", 64'(o_imem_req), 0);
            if (o_imem_req && gnt) begin
                chk("rnd_req_addr", o_imem_addr, model_pc);
                pend = 1; pend_addr = o_imem_addr; pend_dly = $urandom_range(0, 2);
            end

            expect_held = 0; expect_clear = 0;
            if (o_valid) begin
                if (redir || !stall) expect_clear = 1;
                else begin expect_held = 1; held_pc = o_pc; end
            end
            if (redir) model_pc = rpc & ~64'h3;
            else if (o_valid && !stall)
                model_pc = (m_hit(model_pc) && m_taken(model_pc)) ? m_tgt(model_pc) : model_pc + 64'd4;
            prev_valid = o_valid;

            i_imem_gnt = gnt; i_stall_fetch = stall; i_redirect = redir; i_redirect_pc = rpc;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
